// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundle between the byte producers / uart_byte_tx and the round-robin
//   arbiter that shares the transmitter.
//   req_valid/req_data/req_ready : N_REQ producer handshakes (byte i at [8i+7:8i])
//   Send_Go/Data/Baud_set        : start pulse, byte and baud select to uart_byte_tx
//   Tx_done                      : frame-complete pulse from uart_byte_tx
//   busy/grant_id/timeout_err    : arbiter status
//   master : producers + transmitter side, slave : arbiter side
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_ready;
   logic               Send_Go;
   logic [7:0]         Data;
   logic [2:0]         Baud_set;
   logic               Tx_done;
   logic               busy;
   logic [2:0]         grant_id;
   logic               timeout_err;

   modport master (
      output req_valid, req_data, Tx_done,
      input  req_ready, Send_Go, Data, Baud_set, busy, grant_id, timeout_err
   );

   modport slave (
      input  req_valid, req_data, Tx_done,
      output req_ready, Send_Go, Data, Baud_set, busy, grant_id, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter sharing one uart_byte_tx between N_REQ byte sources.
//   A granted byte is latched onto Data, Send_Go and the winner's req_ready
//   pulse together, then the FSM waits for Tx_done (or a timeout) and holds
//   an inter-frame gap before arbitrating again.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high
//     bus   : uart_tx_arbiter_if.slave (handshakes, transmitter, status)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int         N_REQ       = 4,
   parameter int         GAP_CYC     = 16,
   parameter int         TIMEOUT_CYC = 2000000,
   parameter logic [2:0] BAUD_CFG    = 3'd0
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_arbiter_if.slave   bus
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
   // The IDLE arbitration cycle is part of the idle time, so GAP itself lasts
   // GAP_CYC-1 cycles: Send_Go lands GAP_CYC+1 cycles after Tx_done.
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);

   typedef enum logic [1:0] {
      S_IDLE, S_SEND, S_WAIT, S_GAP
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_last;
   logic [2:0]       r_grant_id;
   logic [7:0]       r_data;
   logic             r_send_go;
   logic [N_REQ-1:0] r_req_ready;
   logic             r_timeout_err;

   logic             w_any;
   logic [2:0]       w_win;
   logic [7:0]       w_win_data;
   logic [CW-1:0]    w_cnt_nxt;

   // Search starts just after the last winner, so a requester holding valid
   // is served again only after every other active requester.
   always_comb begin
      w_any      = 1'b0;
      w_win      = '0;
      w_win_data = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!w_any && bus.req_valid[j] && (j == (int'(r_last) + k) % N_REQ)) begin
               w_any = 1'b1;
               w_win = 3'(j);
            end
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         if (w_win == 3'(j)) w_win_data = bus.req_data[8*j +: 8];
      end
   end

   assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_last        <= 3'(N_REQ - 1);
         r_grant_id    <= '0;
         r_data        <= '0;
         r_send_go     <= 1'b0;
         r_req_ready   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_send_go     <= 1'b0;
         r_req_ready   <= '0;
         r_timeout_err <= 1'b0;
         r_cnt         <= w_cnt_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state     <= S_SEND;
                  r_cnt       <= '0;
                  r_data      <= w_win_data;
                  r_grant_id  <= w_win;
                  r_last      <= w_win;
                  r_send_go   <= 1'b1;
                  r_req_ready <= N_REQ'(1) << w_win;
               end
            end
            S_SEND: begin
               r_state <= S_WAIT;
               r_cnt   <= '0;
            end
            S_WAIT: begin
               // Tx_done is checked first so it wins over a same-cycle timeout.
               if (bus.Tx_done) begin
                  r_state <= S_GAP;
                  r_cnt   <= '0;
               end else if (r_cnt >= TO_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= S_GAP;
                  r_cnt         <= '0;
               end
            end
            S_GAP: begin
               if (r_cnt >= GAP_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.Send_Go     = r_send_go;
   assign bus.req_ready   = r_req_ready;
   assign bus.Data        = r_data;
   assign bus.Baud_set    = BAUD_CFG;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.grant_id    = r_grant_id;
   assign bus.timeout_err = r_timeout_err;
endmodule
